// File: rtl/regfile_seq_engine.sv
// Register-file sequencer: seeds r0/r1, then fills r2..r[DEPTH-1] with a
// selectable recurrence (add/sub, optional saturation, sticky overflow).
module regfile_seq_engine #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              sat_en,
    input  logic [WIDTH-1:0]  seed0,
    input  logic [WIDTH-1:0]  seed1,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [ADDR_W-1:0] ovf_idx,
    output logic [ADDR_W-1:0] cur_idx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD0 = 3'd1;
    localparam logic [2:0] S_LOAD1 = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        MODE_DIFF = 2'b01;

    logic [2:0]        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic              sat_q, sat_d;
    logic [WIDTH-1:0]  seed0_q, seed0_d;
    logic [WIDTH-1:0]  seed1_q, seed1_d;
    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [WIDTH-1:0]  regs_d [DEPTH];
    logic              ovf_q, ovf_d;
    logic [ADDR_W-1:0] ovf_idx_q, ovf_idx_d;
    logic [ADDR_W-1:0] cur_idx_q, cur_idx_d;

    logic [ADDR_W-1:0] idx_m1, idx_m2;
    logic [WIDTH-1:0]  prev1, prev2;
    logic [WIDTH:0]    raw;
    logic [WIDTH-1:0]  wr_val;

    // Result carries the carry-out / borrow in its top bit.
    function automatic logic [WIDTH:0] alu(input logic [1:0] m,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [WIDTH-1:0] r0);
        case (m)
            2'b01:   return {1'b0, a} - {1'b0, b};
            2'b10:   return {1'b0, a} + {1'b0, a};
            2'b11:   return {1'b0, a} + {1'b0, r0};
            default: return {1'b0, a} + {1'b0, b};
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH:0] r,
                                                  input logic is_sub,
                                                  input logic sat);
        if (r[WIDTH] && sat) begin
            return is_sub ? '0 : '1;
        end
        return r[WIDTH-1:0];
    endfunction

    assign idx_m1 = cur_idx_q - ADDR_W'(1);
    assign idx_m2 = cur_idx_q - ADDR_W'(2);
    assign prev1  = regs_q[idx_m1];
    assign prev2  = regs_q[idx_m2];
    assign raw    = alu(mode_q, prev1, prev2, regs_q[0]);
    assign wr_val = saturate(raw, mode_q == MODE_DIFF, sat_q);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        sat_d     = sat_q;
        seed0_d   = seed0_q;
        seed1_d   = seed1_q;
        regs_d    = regs_q;
        ovf_d     = ovf_q;
        ovf_idx_d = ovf_idx_q;
        cur_idx_d = cur_idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d    = mode;
                    sat_d     = sat_en;
                    seed0_d   = seed0;
                    seed1_d   = seed1;
                    ovf_d     = 1'b0;
                    ovf_idx_d = '0;
                    cur_idx_d = '0;
                    state_d   = S_LOAD0;
                end
            end
            S_LOAD0: begin
                regs_d[0] = seed0_q;
                cur_idx_d = ADDR_W'(1);
                state_d   = S_LOAD1;
            end
            S_LOAD1: begin
                regs_d[1] = seed1_q;
                cur_idx_d = ADDR_W'(2);
                state_d   = S_RUN;
            end
            S_RUN: begin
                regs_d[cur_idx_q] = wr_val;
                // Only the first overflow of a run is recorded.
                if (raw[WIDTH] && !ovf_q) begin
                    ovf_d     = 1'b1;
                    ovf_idx_d = cur_idx_q;
                end
                if (cur_idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    cur_idx_d = cur_idx_q + ADDR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            sat_q     <= 1'b0;
            seed0_q   <= '0;
            seed1_q   <= '0;
            ovf_q     <= 1'b0;
            ovf_idx_q <= '0;
            cur_idx_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            sat_q     <= sat_d;
            seed0_q   <= seed0_d;
            seed1_q   <= seed1_d;
            ovf_q     <= ovf_d;
            ovf_idx_q <= ovf_idx_d;
            cur_idx_q <= cur_idx_d;
            regs_q    <= regs_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (int'(rd_addr) < DEPTH) begin
            rd_data = regs_q[rd_addr];
        end
    end

    assign busy    = (state_q == S_LOAD0) || (state_q == S_LOAD1) || (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign ovf     = ovf_q;
    assign ovf_idx = ovf_idx_q;
    assign cur_idx = cur_idx_q;

endmodule

// File: tb/tb_regfile_seq_engine.sv
// Bench for regfile_seq_engine: three parameterisations share one stimulus
// stream and are checked each cycle against a sequence-level model.
module tb_regfile_seq_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic        sat_en;
    logic [15:0] seed0, seed1;
    logic [3:0]  rd_addr;

    logic [15:0] rd_a;
    logic [7:0]  rd_b;
    logic [3:0]  rd_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic [3:0]  oi_a, oi_b, ci_a, ci_b;
    logic [2:0]  oi_c, ci_c;

    always #5 clk = ~clk;

    regfile_seq_engine #(.WIDTH(16), .DEPTH(16), .ADDR_W(4)) u_a (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .sat_en(sat_en),
        .seed0(seed0), .seed1(seed1), .rd_addr(rd_addr), .rd_data(rd_a),
        .busy(busy_a), .done(done_a), .ovf(ovf_a), .ovf_idx(oi_a), .cur_idx(ci_a));

    regfile_seq_engine #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) u_b (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .sat_en(sat_en),
        .seed0(seed0[7:0]), .seed1(seed1[7:0]), .rd_addr(rd_addr), .rd_data(rd_b),
        .busy(busy_b), .done(done_b), .ovf(ovf_b), .ovf_idx(oi_b), .cur_idx(ci_b));

    regfile_seq_engine #(.WIDTH(4), .DEPTH(5), .ADDR_W(3)) u_c (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .sat_en(sat_en),
        .seed0(seed0[3:0]), .seed1(seed1[3:0]), .rd_addr(rd_addr[2:0]), .rd_data(rd_c),
        .busy(busy_c), .done(done_c), .ovf(ovf_c), .ovf_idx(oi_c), .cur_idx(ci_c));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- model: whole sequence computed on accept ----------------
    int PW[3] = '{16, 8, 4};
    int PD[3] = '{16, 16, 5};
    int PA[3] = '{4, 4, 3};

    int m_n[3];          // edges since accepted start, -1 when idle
    int m_vals[3][256];  // register contents visible now
    int m_seq[3][256];   // final contents of the current run
    int m_first[3];      // first overflowing index, -1 if none
    int m_ovf[3];
    int m_ovfidx[3];

    function automatic void build(input int i);
        int mask, a, b, v, s;
        bit o;
        mask = (1 << PW[i]) - 1;
        m_seq[i][0] = int'(seed0) & mask;
        m_seq[i][1] = int'(seed1) & mask;
        m_first[i] = -1;
        for (int k = 2; k < PD[i]; k++) begin
            a = m_seq[i][k-1];
            case (mode)
                2'b10:   b = a;
                2'b11:   b = m_seq[i][0];
                default: b = m_seq[i][k-2];
            endcase
            if (mode == 2'b01) begin
                o = a < b;
                v = o ? (sat_en ? 0 : a - b + mask + 1) : a - b;
            end else begin
                s = a + b;
                o = s > mask;
                v = o ? (sat_en ? mask : s - mask - 1) : s;
            end
            if (o && m_first[i] < 0) m_first[i] = k;
            m_seq[i][k] = v;
        end
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                m_n[i] = -1;
                m_ovf[i] = 0;
                m_ovfidx[i] = 0;
                for (int j = 0; j < 256; j++) m_vals[i][j] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_n[i] < 0) begin
                    if (start) begin
                        build(i);
                        m_n[i] = 0;
                        m_ovf[i] = 0;
                        m_ovfidx[i] = 0;
                    end
                end else if (m_n[i] < PD[i]) begin
                    m_n[i]++;
                    m_vals[i][m_n[i]-1] = m_seq[i][m_n[i]-1];
                    if (m_first[i] == m_n[i] - 1) begin
                        m_ovf[i] = 1;
                        m_ovfidx[i] = m_first[i];
                    end
                end else begin
                    m_n[i] = -1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int act_rd[3], act_busy[3], act_done[3], act_ovf[3], act_oi[3], act_ci[3];
        int a, e_rd;
        bit e_busy;
        act_rd   = '{int'(rd_a), int'(rd_b), int'(rd_c)};
        act_busy = '{int'(busy_a), int'(busy_b), int'(busy_c)};
        act_done = '{int'(done_a), int'(done_b), int'(done_c)};
        act_ovf  = '{int'(ovf_a), int'(ovf_b), int'(ovf_c)};
        act_oi   = '{int'(oi_a), int'(oi_b), int'(oi_c)};
        act_ci   = '{int'(ci_a), int'(ci_b), int'(ci_c)};
        for (int i = 0; i < 3; i++) begin
            a = int'(rd_addr) & ((1 << PA[i]) - 1);
            e_rd = (a < PD[i]) ? m_vals[i][a] : 0;
            e_busy = (m_n[i] >= 0) && (m_n[i] < PD[i]);
            check($sformatf("rd_data[%0d]@%0d", i, a), act_rd[i], e_rd);
            check($sformatf("busy[%0d]", i), act_busy[i], int'(e_busy));
            check($sformatf("done[%0d]", i), act_done[i], int'(m_n[i] == PD[i]));
            check($sformatf("ovf[%0d]", i), act_ovf[i], m_ovf[i]);
            check($sformatf("ovf_idx[%0d]", i), act_oi[i], m_ovfidx[i]);
            if (e_busy) check($sformatf("cur_idx[%0d]", i), act_ci[i], m_n[i]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic rd(input int addr);
        @(posedge clk);
        #1 rd_addr = addr[3:0];
        #1;
    endtask

    task automatic run_cfg(input int md, input int sat, input int s0, input int s1,
                           input int inj, output int lat_a, output int lat_c);
        @(posedge clk);
        #1 mode = md[1:0]; sat_en = sat[0]; seed0 = s0[15:0]; seed1 = s1[15:0]; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat_a = -1;
        lat_c = -1;
        for (int e = 1; e <= 24; e++) begin
            @(posedge clk);
            #1;
            if (done_a && lat_a < 0) lat_a = e;
            if (done_c && lat_c < 0) lat_c = e;
            start = (e == inj);
            if (e == inj) begin
                mode = 2'b10; seed0 = 16'd7; seed1 = 16'd9;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int la, lc;
        reset = 1'b0; start = 1'b0; mode = 2'b00; sat_en = 1'b0;
        seed0 = '0; seed1 = '0; rd_addr = '0;
        #3;
        check("reset_busy", int'(busy_a), 0);
        check("reset_done", int'(done_a), 0);
        check("reset_ovf", int'(ovf_a), 0);
        check("reset_cur_idx", int'(ci_a), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Fibonacci 0,1: 16-bit clean, 8-bit wraps at r14
        run_cfg(0, 0, 0, 1, -1, la, lc);
        check("lat_done_a", la, 16);
        check("lat_done_c", lc, 5);
        rd(2);  check("fib_r2", int'(rd_a), 1);
        rd(10); check("fib_r10", int'(rd_a), 55);
        rd(15); check("fib_r15", int'(rd_a), 610);
        check("fib_ovf_a", int'(ovf_a), 0);
        rd(13); check("w8_r13", int'(rd_b), 233);
        rd(14); check("w8_r14_wrap", int'(rd_b), 121);
        rd(15); check("w8_r15_wrap", int'(rd_b), 98);
        check("w8_ovf", int'(ovf_b), 1);
        check("w8_ovf_idx", int'(oi_b), 14);

        // Same with saturation
        run_cfg(0, 1, 0, 1, -1, la, lc);
        rd(14); check("w8_r14_sat", int'(rd_b), 255);
        rd(15); check("w8_r15_sat", int'(rd_b), 255);
        check("w8_sat_ovf_idx", int'(oi_b), 14);

        // Difference with borrow
        run_cfg(1, 0, 5, 3, -1, la, lc);
        rd(2); check("diff_r2", int'(rd_a), 16'hFFFE);
        check("diff_ovf", int'(ovf_a), 1);
        check("diff_ovf_idx", int'(oi_a), 2);

        // Arithmetic progression 3,5: r15 = 5 + 14*3
        run_cfg(3, 0, 3, 5, -1, la, lc);
        rd(15); check("ap_r15", int'(rd_a), 47);
        check("ap_ovf", int'(ovf_a), 0);

        // Doubling 0,1: r15 = 2**14
        run_cfg(2, 0, 0, 1, -1, la, lc);
        rd(15); check("dbl_r15", int'(rd_a), 16384);

        // Small instance: 4-bit, depth 5, seeds 15,15
        run_cfg(0, 0, 15, 15, -1, la, lc);
        check("d5_lat", lc, 5);
        rd(2); check("d5_r2", int'(rd_c), 14);
        rd(3); check("d5_r3", int'(rd_c), 13);
        rd(4); check("d5_r4", int'(rd_c), 11);
        check("d5_ovf_idx", int'(oi_c), 2);
        rd(7); check("d5_rd_oob", int'(rd_c), 0);

        // Start pulsed mid-run is ignored
        run_cfg(0, 0, 0, 1, 6, la, lc);
        check("ign_lat", la, 16);
        rd(10); check("ign_r10", int'(rd_a), 55);
        rd(15); check("ign_r15", int'(rd_a), 610);

        // Reset mid-run
        @(posedge clk);
        #1 mode = 2'b00; sat_en = 1'b0; seed0 = 16'd0; seed1 = 16'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_busy_a", int'(busy_a), 0);
        check("rst_busy_b", int'(busy_b), 0);
        check("rst_busy_c", int'(busy_c), 0);
        for (int k = 0; k < 16; k++) begin
            rd(k);
            check($sformatf("rst_rd_a%0d", k), int'(rd_a), 0);
            check($sformatf("rst_rd_b%0d", k), int'(rd_b), 0);
            check($sformatf("rst_rd_c%0d", k), int'(rd_c), 0);
        end
        @(posedge clk);
        #1 reset = 1'b1;

        run_cfg(0, 0, 0, 1, -1, la, lc);
        check("post_rst_lat", la, 16);
        rd(15); check("post_rst_r15", int'(rd_a), 610);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
